// File: rtl/rtc_bus_ctrl.sv
// rtl/rtc_bus_ctrl.sv - RTC multiplexed address/data bus sequencer (one read or write per request)
// Optional post-transaction recovery window enabled by defining RTC_RECOVERY_EN.
module rtc_bus_ctrl #(
  parameter int PHASE_CYC = 4
`ifdef RTC_RECOVERY_EN
  , parameter int RECOV_CYC = 8
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_wr,
  input  logic       req_rd,
  input  logic [7:0] addr_in,
  input  logic [7:0] wdata_in,
  output logic [7:0] direccion,
  output logic [7:0] dato_escribir,
  output logic       ad_sel,
  output logic       escribir_dato,
  output logic       leer_dato,
  output logic       cs_n,
  output logic       as,
  output logic       rd_n,
  output logic       wr_n,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(PHASE_CYC + 1);
  localparam logic [CW-1:0] PH_LAST = CW'(PHASE_CYC - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_LATCH, S_TURN, S_WDATA, S_RDATA, S_HOLD, S_DONE
`ifdef RTC_RECOVERY_EN
    , S_RECOV
`endif
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          is_wr, is_wr_nxt;
  logic          accept, ph_last;
  logic          ad_sel_d, esc_d, leer_d, cs_n_d, as_d, rd_n_d, wr_n_d, busy_d, done_d;

`ifdef RTC_RECOVERY_EN
  localparam int RW = $clog2(RECOV_CYC + 1);
  localparam logic [RW-1:0] R_LAST = RW'(RECOV_CYC - 1);
  logic [RW-1:0] rcnt, rcnt_nxt;
`endif

  assign accept  = (state == S_IDLE) && (req_wr || req_rd);
  assign ph_last = (cnt == PH_LAST);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    is_wr_nxt = is_wr;
`ifdef RTC_RECOVERY_EN
    rcnt_nxt  = rcnt;
`endif
    case (state)
      S_IDLE: begin
        if (req_wr || req_rd) begin
          state_nxt = S_ADDR;
          cnt_nxt   = '0;
          // A simultaneous read is dropped: write has priority.
          is_wr_nxt = req_wr;
        end
      end
      S_ADDR, S_LATCH, S_TURN, S_WDATA, S_RDATA, S_HOLD: begin
        if (ph_last) begin
          cnt_nxt = '0;
          case (state)
            S_ADDR:  state_nxt = S_LATCH;
            S_LATCH: state_nxt = S_TURN;
            S_TURN:  state_nxt = is_wr ? S_WDATA : S_RDATA;
            S_WDATA: state_nxt = S_HOLD;
            S_RDATA: state_nxt = S_HOLD;
            default: state_nxt = S_DONE;
          endcase
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_DONE: begin
        cnt_nxt = '0;
`ifdef RTC_RECOVERY_EN
        state_nxt = S_RECOV;
        rcnt_nxt  = '0;
`else
        state_nxt = S_IDLE;
`endif
      end
`ifdef RTC_RECOVERY_EN
      S_RECOV: begin
        if (rcnt == R_LAST) state_nxt = S_IDLE;
        else                rcnt_nxt  = rcnt + RW'(1);
      end
`endif
      default: state_nxt = S_IDLE;
    endcase

    // Strobes are registered, so decode them from where the FSM is going.
    ad_sel_d = 1'b0;
    esc_d    = 1'b0;
    leer_d   = 1'b0;
    cs_n_d   = 1'b1;
    as_d     = 1'b0;
    rd_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_nxt)
      S_ADDR:  begin cs_n_d = 1'b0; as_d = 1'b1; esc_d = 1'b1; busy_d = 1'b1; end
      S_LATCH: begin cs_n_d = 1'b0; esc_d = 1'b1; busy_d = 1'b1; end
      S_TURN:  begin cs_n_d = 1'b0; ad_sel_d = 1'b1; esc_d = is_wr_nxt; busy_d = 1'b1; end
      S_WDATA: begin cs_n_d = 1'b0; ad_sel_d = 1'b1; esc_d = 1'b1; wr_n_d = 1'b0; busy_d = 1'b1; end
      S_RDATA: begin
        cs_n_d   = 1'b0;
        ad_sel_d = 1'b1;
        rd_n_d   = 1'b0;
        busy_d   = 1'b1;
        leer_d   = (cnt_nxt == PH_LAST);
      end
      S_HOLD:  begin cs_n_d = 1'b0; ad_sel_d = 1'b1; esc_d = is_wr_nxt; busy_d = 1'b1; end
      S_DONE:  begin busy_d = 1'b1; done_d = 1'b1; end
`ifdef RTC_RECOVERY_EN
      S_RECOV: busy_d = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      is_wr         <= 1'b0;
      direccion     <= '0;
      dato_escribir <= '0;
      ad_sel        <= 1'b0;
      escribir_dato <= 1'b0;
      leer_dato     <= 1'b0;
      cs_n          <= 1'b1;
      as            <= 1'b0;
      rd_n          <= 1'b1;
      wr_n          <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
`ifdef RTC_RECOVERY_EN
      rcnt          <= '0;
`endif
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      is_wr         <= is_wr_nxt;
      ad_sel        <= ad_sel_d;
      escribir_dato <= esc_d;
      leer_dato     <= leer_d;
      cs_n          <= cs_n_d;
      as            <= as_d;
      rd_n          <= rd_n_d;
      wr_n          <= wr_n_d;
      busy          <= busy_d;
      done          <= done_d;
`ifdef RTC_RECOVERY_EN
      rcnt          <= rcnt_nxt;
`endif
      if (accept) begin
        direccion <= addr_in;
        if (req_wr) dato_escribir <= wdata_in;
      end
    end
  end

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// tb/tb_rtc_bus_ctrl.sv - directed vector bench for rtc_bus_ctrl with a small RTC/datapath model
module tb_rtc_bus_ctrl;

  localparam int P = 4;
  localparam int LAT = 1 + 5 * P;
`ifdef RTC_RECOVERY_EN
  localparam int POST_BUSY = 8;
`else
  localparam int POST_BUSY = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       req_wr, req_rd;
  logic [7:0] addr_in, wdata_in;
  logic [7:0] direccion, dato_escribir;
  logic       ad_sel, escribir_dato, leer_dato, cs_n, as, rd_n, wr_n, busy, done;

  always #5 clk = ~clk;

  rtc_bus_ctrl dut (
    .clk(clk), .reset(reset), .req_wr(req_wr), .req_rd(req_rd),
    .addr_in(addr_in), .wdata_in(wdata_in), .direccion(direccion),
    .dato_escribir(dato_escribir), .ad_sel(ad_sel), .escribir_dato(escribir_dato),
    .leer_dato(leer_dato), .cs_n(cs_n), .as(as), .rd_n(rd_n), .wr_n(wr_n),
    .busy(busy), .done(done)
  );

  // Datapath + RTC model: bus mux, latched RTC address, register file, read register.
  logic [7:0] mem [0:255];
  logic [7:0] rtc_lat, datoleer, bus;

  always_comb begin
    if (escribir_dato)       bus = ad_sel ? dato_escribir : direccion;
    else if (!rd_n && !cs_n) bus = mem[rtc_lat];
    else                     bus = 8'hFF;
  end

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i == 0) ? 8'h59 : 8'h00;
      rtc_lat  <= 8'h00;
      datoleer <= 8'h00;
    end else begin
      if (!cs_n && as)    rtc_lat      <= bus;
      if (!cs_n && !wr_n) mem[rtc_lat] <= bus;
      if (leer_dato)      datoleer     <= bus;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       rw;
    logic       rr;
    logic [7:0] a;
    logic [7:0] d;
    int         inj;
    int         exp_wr_lo;
    int         exp_rd_lo;
    int         exp_leer;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs [6];

  task automatic run_vec(input int idx, input vec_t v);
    int cyc, lat, wr_lo, rd_lo, leer, leer_bad, addr_err, data_err, ovl, esc_rd, busy_gap;
    int pb, pd, pc;
    bit got_done;
    cyc = 1; lat = 0; wr_lo = 0; rd_lo = 0; leer = 0; leer_bad = 0;
    addr_err = 0; data_err = 0; ovl = 0; esc_rd = 0; busy_gap = 0; got_done = 0;
    @(negedge clk);
    req_wr = v.rw; req_rd = v.rr; addr_in = v.a; wdata_in = v.d;
    @(negedge clk);
    req_wr = 1'b0; req_rd = 1'b0; addr_in = 8'hEE; wdata_in = 8'hDD;
    while (cyc <= 200 && !got_done) begin
      req_rd = (cyc == v.inj);
      if (!busy) busy_gap++;
      if (as && bus != v.a) addr_err++;
      if (!wr_n) begin wr_lo++; if (bus != v.d) data_err++; end
      if (!rd_n) rd_lo++;
      if (!rd_n && !wr_n) ovl++;
      if (!rd_n && escribir_dato) esc_rd++;
      if (leer_dato) begin leer++; if (rd_n || rd_lo != P) leer_bad++; end
      if (done) begin
        got_done = 1'b1;
        lat = cyc;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    req_rd = 1'b0;
    chk($sformatf("v%0d done_seen", idx), int'(got_done), 1);
    chk($sformatf("v%0d done_latency", idx), lat, LAT);
    chk($sformatf("v%0d wr_n_low_cycles", idx), wr_lo, v.exp_wr_lo);
    chk($sformatf("v%0d rd_n_low_cycles", idx), rd_lo, v.exp_rd_lo);
    chk($sformatf("v%0d leer_count", idx), leer, v.exp_leer);
    chk($sformatf("v%0d leer_position", idx), leer_bad, 0);
    chk($sformatf("v%0d addr_on_bus", idx), addr_err, 0);
    chk($sformatf("v%0d wdata_on_bus", idx), data_err, 0);
    chk($sformatf("v%0d rd_wr_overlap", idx), ovl, 0);
    chk($sformatf("v%0d drive_while_rd", idx), esc_rd, 0);
    chk($sformatf("v%0d busy_gap", idx), busy_gap, 0);
    if (v.rr && !v.rw) chk($sformatf("v%0d read_data", idx), int'(datoleer), int'(v.exp_rd));
    pb = 0; pd = 0; pc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy) pb++;
      if (done) pd++;
      if (!cs_n) pc++;
    end
    chk($sformatf("v%0d post_busy", idx), pb, POST_BUSY);
    chk($sformatf("v%0d post_done", idx), pd, 0);
    chk($sformatf("v%0d post_cs", idx), pc, 0);
  endtask

  initial begin
    int n, nd, ncs;
    vecs[0] = '{1'b1, 1'b0, 8'h0A, 8'h26, 0,  P, 0, 0, 8'h00};
    vecs[1] = '{1'b0, 1'b1, 8'h00, 8'h00, 0,  0, P, 1, 8'h59};
    vecs[2] = '{1'b1, 1'b1, 8'h10, 8'h77, 0,  P, 0, 0, 8'h00};
    vecs[3] = '{1'b0, 1'b1, 8'h10, 8'h00, 0,  0, P, 1, 8'h77};
    vecs[4] = '{1'b1, 1'b0, 8'h20, 8'hAB, 10, P, 0, 0, 8'h00};
    vecs[5] = '{1'b0, 1'b1, 8'h20, 8'h00, 0,  0, P, 1, 8'hAB};

    reset = 1'b1; req_wr = 1'b0; req_rd = 1'b0; addr_in = 8'h00; wdata_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_strobes", int'({cs_n, as, rd_n, wr_n, escribir_dato, ad_sel, leer_dato}), 7'b1011000);
    chk("reset_busy_done", int'({busy, done}), 0);
    chk("reset_regs", int'({direccion, dato_escribir}), 0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Reset in the middle of the write data phase.
    @(negedge clk);
    req_wr = 1'b1; addr_in = 8'h33; wdata_in = 8'h44;
    @(negedge clk);
    req_wr = 1'b0;
    n = 0;
    while (wr_n && n < 40) begin @(negedge clk); n++; end
    chk("midreset_reached_wdata", int'(wr_n), 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_strobes", int'({cs_n, as, rd_n, wr_n, escribir_dato, ad_sel, leer_dato}), 7'b1011000);
    chk("midreset_busy_done", int'({busy, done}), 0);
    chk("midreset_direccion", int'(direccion), 0);
    nd = 0; ncs = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) nd++;
      if (!cs_n) ncs++;
    end
    chk("midreset_no_done", nd, 0);
    chk("midreset_idle", ncs, 0);

    run_vec(6, '{1'b0, 1'b1, 8'h00, 8'h00, 0, 0, P, 1, 8'h59});

`ifdef RTC_RECOVERY_EN
    // A request three cycles after done must be swallowed by the recovery window.
    @(negedge clk);
    req_wr = 1'b1; addr_in = 8'h05; wdata_in = 8'h06;
    @(negedge clk);
    req_wr = 1'b0;
    n = 0;
    while (!done && n < 60) begin @(negedge clk); n++; end
    chk("recov_done_seen", int'(done), 1);
    nd = 0; ncs = 0;
    for (int i = 1; i <= 12; i++) begin
      req_wr = (i == 3);
      @(negedge clk);
      if (busy) nd++;
      if (!cs_n) ncs++;
    end
    req_wr = 1'b0;
    chk("recov_busy_cycles", nd, 8);
    chk("recov_req_ignored", ncs, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
